// File: rtl/alu_lane_serializer_pkg.sv
// Shared types and sizing helpers for the ALU lane serializer.
// The DEF_* localparams describe the default warp geometry used by alu_batch_t.
package alu_lane_serializer_pkg;

    function automatic int calc_num_pkts(input int num_threads, input int num_lanes);
        return num_threads / num_lanes;
    endfunction

    // A single-batch warp still needs a 1-bit pid field.
    function automatic int calc_pid_width(input int num_pkts);
        return (num_pkts > 1) ? $clog2(num_pkts) : 1;
    endfunction

    localparam int DEF_NUM_THREADS = 4;
    localparam int DEF_NUM_LANES   = 1;
    localparam int DEF_HDRW        = 64;
    localparam int DEF_XLEN        = 32;
    localparam int DEF_NUM_PKTS    = calc_num_pkts(DEF_NUM_THREADS, DEF_NUM_LANES);
    localparam int DEF_PID_WIDTH   = calc_pid_width(DEF_NUM_PKTS);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_t;

    typedef struct packed {
        logic [DEF_HDRW-1:0]               hdr;
        logic [DEF_NUM_LANES-1:0]          tmask;
        logic [DEF_NUM_LANES*DEF_XLEN-1:0] rs1;
        logic [DEF_NUM_LANES*DEF_XLEN-1:0] rs2;
        logic [DEF_PID_WIDTH-1:0]          pid;
        logic                              sop;
        logic                              eop;
    } alu_batch_t;

endpackage

// File: rtl/alu_lane_serializer_pick.sv
// Combinational batch finder: first/last active batch of an incoming warp and
// the next active batch after the current pid of the latched warp.
module alu_lane_pick #(
    parameter int NUM_PKTS  = 4,
    parameter int PID_WIDTH = 2
) (
    input  logic [NUM_PKTS-1:0]  new_nz,
    input  logic [NUM_PKTS-1:0]  cur_nz,
    input  logic [PID_WIDTH-1:0] cur_pid,
    output logic [PID_WIDTH-1:0] first,
    output logic [PID_WIDTH-1:0] next,
    output logic [PID_WIDTH-1:0] last
);

    // An all-zero mask yields first=last=0 so the warp still emits one batch.
    always_comb begin
        first = '0;
        last  = '0;
        next  = cur_pid;
        for (int p = NUM_PKTS - 1; p >= 0; p--) begin
            if (new_nz[p]) first = PID_WIDTH'(p);
        end
        for (int p = 0; p < NUM_PKTS; p++) begin
            if (new_nz[p]) last = PID_WIDTH'(p);
        end
        for (int p = NUM_PKTS - 1; p >= 0; p--) begin
            if (cur_nz[p] && (p > int'(cur_pid))) next = PID_WIDTH'(p);
        end
    end

endmodule

// File: rtl/alu_lane_serializer.sv
// Splits a full-warp ALU request into NUM_LANES-wide batches tagged with pid/sop/eop.
// Define ALU_LANE_SKIP_EN to skip batches whose thread-mask slice is all zero.
//
// state  | meaning
// S_IDLE | no warp held, ready for a new request
// S_SEND | warp latched, presenting batch pid_r
module alu_lane_serializer
    import alu_lane_serializer_pkg::*;
#(
    parameter int NUM_THREADS = DEF_NUM_THREADS,
    parameter int NUM_LANES   = DEF_NUM_LANES,
    parameter int HDRW        = DEF_HDRW,
    parameter int XLEN        = DEF_XLEN,
    localparam int NUM_PKTS   = calc_num_pkts(NUM_THREADS, NUM_LANES),
    localparam int PID_WIDTH  = calc_pid_width(NUM_PKTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [HDRW-1:0]             in_hdr,
    input  logic [NUM_THREADS-1:0]      in_tmask,
    input  logic [NUM_THREADS*XLEN-1:0] in_rs1,
    input  logic [NUM_THREADS*XLEN-1:0] in_rs2,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [HDRW-1:0]             out_hdr,
    output logic [NUM_LANES-1:0]        out_tmask,
    output logic [NUM_LANES*XLEN-1:0]   out_rs1,
    output logic [NUM_LANES*XLEN-1:0]   out_rs2,
    output logic [PID_WIDTH-1:0]        out_pid,
    output logic                        out_sop,
    output logic                        out_eop
);

    ser_state_t                  state_r;
    logic                        busy_r;
    logic [PID_WIDTH-1:0]        pid_r;
    logic [HDRW-1:0]             hdr_r;
    logic [NUM_THREADS-1:0]      tmask_r;
    logic [NUM_THREADS*XLEN-1:0] rs1_r;
    logic [NUM_THREADS*XLEN-1:0] rs2_r;
    logic [PID_WIDTH-1:0]        first_sel;
    logic [PID_WIDTH-1:0]        next_sel;
    logic [PID_WIDTH-1:0]        first_r;
    logic [PID_WIDTH-1:0]        last_r;
    logic                        in_fire;
    logic                        out_fire;

    assign busy_r = (state_r == S_SEND);

    // Gated by reset so nothing fires while a synchronous reset is pending.
    assign out_valid = busy_r & ~reset;
    assign out_fire  = out_valid & out_ready;
    assign in_ready  = ~reset & (~busy_r | (out_fire & out_eop));
    assign in_fire   = in_valid & in_ready;

`ifdef ALU_LANE_SKIP_EN
    logic [NUM_PKTS-1:0]  in_nz;
    logic [NUM_PKTS-1:0]  cur_nz;
    logic [PID_WIDTH-1:0] last_sel;

    always_comb begin
        in_nz  = '0;
        cur_nz = '0;
        for (int p = 0; p < NUM_PKTS; p++) begin
            in_nz[p]  = |in_tmask[p*NUM_LANES +: NUM_LANES];
            cur_nz[p] = |tmask_r[p*NUM_LANES +: NUM_LANES];
        end
    end

    alu_lane_pick #(
        .NUM_PKTS  (NUM_PKTS),
        .PID_WIDTH (PID_WIDTH)
    ) u_pick (
        .new_nz  (in_nz),
        .cur_nz  (cur_nz),
        .cur_pid (pid_r),
        .first   (first_sel),
        .next    (next_sel),
        .last    (last_sel)
    );

    always_ff @(posedge clk) begin
        if (in_fire) begin
            first_r <= first_sel;
            last_r  <= last_sel;
        end
    end
`else
    assign first_sel = '0;
    assign next_sel  = pid_r + PID_WIDTH'(1);
    assign first_r   = '0;
    assign last_r    = PID_WIDTH'(NUM_PKTS - 1);
`endif

    // A load in the eop cycle takes priority so back-to-back warps have no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            pid_r   <= '0;
        end else if (in_fire) begin
            state_r <= S_SEND;
            pid_r   <= first_sel;
        end else if (out_fire) begin
            if (out_eop) state_r <= S_IDLE;
            else         pid_r   <= next_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            hdr_r   <= in_hdr;
            tmask_r <= in_tmask;
            rs1_r   <= in_rs1;
            rs2_r   <= in_rs2;
        end
    end

    assign out_hdr   = hdr_r;
    assign out_tmask = tmask_r[pid_r*NUM_LANES +: NUM_LANES];
    assign out_rs1   = rs1_r[pid_r*NUM_LANES*XLEN +: NUM_LANES*XLEN];
    assign out_rs2   = rs2_r[pid_r*NUM_LANES*XLEN +: NUM_LANES*XLEN];
    assign out_pid   = pid_r;
    assign out_sop   = (pid_r == first_r);
    assign out_eop   = (pid_r == last_r);

endmodule
